aes_hmac_feeder: RTL

//   Upstream feeder for the AES+HMAC core. Buffers a host byte stream (valid/ready) into one
//   key frame (salt[16] || password[16], 1..32 bytes) and one message frame (1..16 bytes).

---
 rtl/aes_hmac_feeder_pkg.sv | 22 ++
 rtl/aes_hmac_feeder_if.sv | 27 ++
 rtl/aes_hmac_feeder_byte_buf.sv | 41 ++++
 rtl/aes_hmac_feeder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/aes_hmac_feeder_pkg.sv
// Shared constants and state encoding for the AES+HMAC feeder.
package aes_hmac_feeder_pkg;

    localparam int KEY_BYTES = 32;
    localparam int MSG_BYTES = 16;
    localparam int RES_BYTES = 48;

    localparam int ERR_KEY_OVF = 0;
    localparam int ERR_MSG_OVF = 1;
    localparam int ERR_RES_CNT = 2;

    typedef enum logic [2:0] {
        KEY_LOAD,
        KEY_SEND,
        WAIT_KEY_HI,
        WAIT_KEY_LO,
        MSG_SEND,
        WAIT_DONE_HI,
        WAIT_DONE_LO
    } state_e;

endpackage

// File: rtl/aes_hmac_feeder_if.sv
// Host byte stream plus core start/data/phase signals seen by the feeder.
interface aes_hmac_feeder_if;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_mode;
    logic       s_ready;

    logic       top_start;
    logic [7:0] top_data;
    logic       top_mode;
    logic       top_ien;
    logic       top_valid;

    // master: the feeder, which drives the core bus and the host ready
    modport master (
        input  s_valid, s_data, s_last, s_mode, top_ien, top_valid,
        output s_ready, top_start, top_data, top_mode
    );

    modport slave (
        output s_valid, s_data, s_last, s_mode, top_ien, top_valid,
        input  s_ready, top_start, top_data, top_mode
    );

endinterface

// File: rtl/aes_hmac_feeder_byte_buf.sv
// Byte register file filled in order; count doubles as write pointer.
module byte_buf #(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [7:0]    mem_q [DEPTH];
    logic [CW-1:0] count_q;

    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (wr_en && !full) begin
            count_q <= count_q + CW'(1);
        end
    end

    // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en && !full && !clr) begin
            mem_q[count_q[IW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/aes_hmac_feeder.sv
// Buffers one key and one message frame, replays them as gap-free core bursts.
module aes_hmac_feeder
    import aes_hmac_feeder_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    aes_hmac_feeder_if.master         bus,
    output logic                      busy,
    output logic [15:0]               txn_count,
    output logic [2:0]                err
);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [5:0]  res_cnt_q, res_cnt_d, res_inc;
    logic        msg_done_q, msg_done_d;
    logic        start_q, start_d;
    logic [7:0]  data_q, data_d;
    logic        mode_q, mode_d;
    logic [15:0] txn_q, txn_d;
    logic [2:0]  err_q, err_d;

    logic        msg_phase, s_ready, hs, buf_clr;
    logic [5:0]  idx_next;
    logic [4:0]  key_rd_idx;
    logic [3:0]  msg_rd_idx;
    logic [7:0]  key_rd_data, msg_rd_data;
    logic [5:0]  klen;
    logic [4:0]  mlen;
    logic        key_full, msg_full, key_wr, msg_wr;

    assign msg_phase  = (state_q == KEY_SEND) || (state_q == WAIT_KEY_HI) || (state_q == WAIT_KEY_LO);
    assign s_ready    = (state_q == KEY_LOAD) || (msg_phase && !msg_done_q);
    assign hs         = bus.s_valid && s_ready;
    assign idx_next   = {1'b0, idx_q} + 6'd1;
    assign key_rd_idx = (state_q == KEY_SEND) ? idx_next[4:0] : 5'd0;
    assign msg_rd_idx = (state_q == MSG_SEND) ? idx_next[3:0] : 4'd0;
    assign key_wr     = hs && (state_q == KEY_LOAD) && !key_full;
    assign msg_wr     = hs && msg_phase && !msg_full;
    assign res_inc    = (bus.top_valid && res_cnt_q != 6'h3F) ? res_cnt_q + 6'd1 : res_cnt_q;

    byte_buf #(.DEPTH(KEY_BYTES)) u_key_buf (
        .clk(clk), .rst(rst), .clr(buf_clr), .wr_en(key_wr), .wr_data(bus.s_data),
        .rd_idx(key_rd_idx), .rd_data(key_rd_data), .count(klen), .full(key_full)
    );

    byte_buf #(.DEPTH(MSG_BYTES)) u_msg_buf (
        .clk(clk), .rst(rst), .clr(buf_clr), .wr_en(msg_wr), .wr_data(bus.s_data),
        .rd_idx(msg_rd_idx), .rd_data(msg_rd_data), .count(mlen), .full(msg_full)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        res_cnt_d  = res_cnt_q;
        msg_done_d = msg_done_q;
        start_d    = 1'b0;
        data_d     = 8'h00;
        mode_d     = mode_q;
        txn_d      = txn_q;
        err_d      = err_q;
        buf_clr    = 1'b0;

        if (msg_phase && hs) begin
            if (mlen == 5'(MSG_BYTES - 1) && !bus.s_last) err_d[ERR_MSG_OVF] = 1'b1;
            if (bus.s_last) msg_done_d = 1'b1;
        end

        case (state_q)
            KEY_LOAD: if (hs) begin
                if (klen == 6'd0) mode_d = bus.s_mode;
                if (klen == 6'(KEY_BYTES - 1) && !bus.s_last) err_d[ERR_KEY_OVF] = 1'b1;
                if (bus.s_last) begin
                    // a one-byte frame is still being written, so forward it directly
                    state_d = KEY_SEND;
                    start_d = 1'b1;
                    idx_d   = 5'd0;
                    data_d  = (klen == 6'd0) ? bus.s_data : key_rd_data;
                end
            end
            KEY_SEND: begin
                if (idx_next < klen) begin
                    start_d = 1'b1;
                    data_d  = key_rd_data;
                    idx_d   = idx_next[4:0];
                end else begin
                    state_d = WAIT_KEY_HI;
                end
            end
            WAIT_KEY_HI: if (bus.top_ien) state_d = WAIT_KEY_LO;
            WAIT_KEY_LO: if (!bus.top_ien && msg_done_q) begin
                state_d = MSG_SEND;
                start_d = 1'b1;
                idx_d   = 5'd0;
                data_d  = (mlen != 5'd0) ? msg_rd_data : 8'h00;
            end
            MSG_SEND: begin
                if (idx_q != 5'(MSG_BYTES - 1)) begin
                    start_d = 1'b1;
                    idx_d   = idx_next[4:0];
                    data_d  = (idx_next < {1'b0, mlen}) ? msg_rd_data : 8'h00;
                end else begin
                    state_d   = WAIT_DONE_HI;
                    res_cnt_d = 6'd0;
                end
            end
            WAIT_DONE_HI: begin
                res_cnt_d = res_inc;
                if (bus.top_ien) state_d = WAIT_DONE_LO;
            end
            WAIT_DONE_LO: begin
                if (!bus.top_ien) begin
                    if (res_cnt_q != 6'(RES_BYTES)) err_d[ERR_RES_CNT] = 1'b1;
                    txn_d      = txn_q + 16'd1;
                    buf_clr    = 1'b1;
                    msg_done_d = 1'b0;
                    state_d    = KEY_LOAD;
                end else begin
                    res_cnt_d = res_inc;
                end
            end
            default: state_d = KEY_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= KEY_LOAD;
            idx_q      <= '0;
            res_cnt_q  <= '0;
            msg_done_q <= 1'b0;
            start_q    <= 1'b0;
            data_q     <= '0;
            mode_q     <= 1'b0;
            txn_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            res_cnt_q  <= res_cnt_d;
            msg_done_q <= msg_done_d;
            start_q    <= start_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            txn_q      <= txn_d;
            err_q      <= err_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.top_start = start_q;
    assign bus.top_data  = data_q;
    assign bus.top_mode  = mode_q;
    assign busy          = (state_q != KEY_LOAD);
    assign txn_count     = txn_q;
    assign err           = err_q;

endmodule
